// File: rtl/execute_pipe.sv
// Y86-64 execute stage: ALU, condition codes and branch/cmov condition evaluation,
// presented through a one-deep valid/ready output register with flush.
module execute_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             cc_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       icode_o,
  output logic [3:0]       ifun_o,
  output logic [WIDTH-1:0] valE,
  output logic [WIDTH-1:0] valA_o,
  output logic             cnd,
  output logic             err,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH-1:0] StackStep = WIDTH'(STACK_STEP);

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] ICmov   = 4'h2;
  localparam logic [3:0] IIrmov  = 4'h3;
  localparam logic [3:0] IRmmov  = 4'h4;
  localparam logic [3:0] IMrmov  = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPush   = 4'hA;
  localparam logic [3:0] IPop    = 4'hB;

  logic             out_valid_q;
  logic [3:0]       icode_q, ifun_q;
  logic [WIDTH-1:0] val_e_q, val_a_q;
  logic             cnd_q, err_q;
  logic             zf_q, sf_q, of_q;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of, alu_bad;
  logic             cond_ok, cond_bad;
  logic [WIDTH-1:0] val_e_d;
  logic             cnd_d, err_d;
  logic             cc_wr;

  // Reset is folded in so nothing is taken while the stage is being cleared.
  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_bad = 1'b0;
    case (ifun)
      4'h0: begin
        alu_res = valB + valA;
        alu_of  = (valA[Msb] == valB[Msb]) && (alu_res[Msb] != valA[Msb]);
      end
      4'h1: begin
        alu_res = valB - valA;
        alu_of  = (valA[Msb] != valB[Msb]) && (alu_res[Msb] != valB[Msb]);
      end
      4'h2:    alu_res = valB & valA;
      4'h3:    alu_res = valB ^ valA;
      default: alu_bad = 1'b1;
    endcase
  end

  // Evaluated against the current CC register, which already reflects an OPq
  // accepted on the previous edge.
  always_comb begin
    cond_ok  = 1'b0;
    cond_bad = 1'b0;
    case (ifun)
      4'h0:    cond_ok = 1'b1;
      4'h1:    cond_ok = (sf_q ^ of_q) | zf_q;
      4'h2:    cond_ok = sf_q ^ of_q;
      4'h3:    cond_ok = zf_q;
      4'h4:    cond_ok = !zf_q;
      4'h5:    cond_ok = !(sf_q ^ of_q);
      4'h6:    cond_ok = !(sf_q ^ of_q) && !zf_q;
      default: cond_bad = 1'b1;
    endcase
  end

  always_comb begin
    val_e_d = '0;
    cnd_d   = 1'b0;
    err_d   = 1'b0;
    case (icode)
      IHalt, INop: val_e_d = '0;
      ICmov: begin
        val_e_d = valA;
        cnd_d   = cond_ok;
        err_d   = cond_bad;
      end
      IIrmov:         val_e_d = valC;
      IRmmov, IMrmov: val_e_d = valB + valC;
      IOpq: begin
        val_e_d = alu_res;
        err_d   = alu_bad;
      end
      IJxx: begin
        cnd_d = cond_ok;
        err_d = cond_bad;
      end
      ICall, IPush: val_e_d = valB - StackStep;
      IRet, IPop:   val_e_d = valB + StackStep;
      default:      err_d   = 1'b1;
    endcase
  end

  assign cc_wr = accept && (icode == IOpq) && !alu_bad && cc_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      icode_q     <= '0;
      ifun_q      <= '0;
      val_e_q     <= '0;
      val_a_q     <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        icode_q     <= icode;
        ifun_q      <= ifun;
        val_e_q     <= val_e_d;
        val_a_q     <= valA;
        cnd_q       <= cnd_d;
        err_q       <= err_d;
      end else if (flush || out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (cc_wr) begin
        zf_q <= (alu_res == '0);
        sf_q <= alu_res[Msb];
        of_q <= alu_of;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign icode_o   = icode_q;
  assign ifun_o    = ifun_q;
  assign valE      = val_e_q;
  assign valA_o    = val_a_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule
